// File: rtl/spi_flash_cmd_seq.sv
// Sequencer that takes a command packet from the EP2 OUT buffer, plays its bytes
// to the SPI flash under a single chip-select window and echoes the exchange into EP1 IN.
module spi_flash_cmd_seq #(
  parameter int J_CMD_SPI = 30,
  parameter int MAX_LEN   = 512,
  parameter int CS_GAP    = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_hasdata,
  input  logic [9:0]  cmd_len,
  output logic [10:0] cmd_addr,
  input  logic [7:0]  cmd_q,
  output logic        cmd_arm,
  input  logic        cmd_arm_ack,
  output logic        spi_cs_n,
  output logic        spi_start,
  output logic [7:0]  spi_tx,
  input  logic [7:0]  spi_rx,
  input  logic        spi_done,
  output logic [10:0] rsp_addr,
  output logic [7:0]  rsp_data,
  output logic        rsp_wren,
  input  logic        rsp_ready,
  output logic        rsp_commit,
  output logic [10:0] rsp_commit_len,
  input  logic        rsp_commit_ack,
  output logic        busy
);

  typedef enum logic [3:0] {
    IDLE, FETCH, CHECK, CS_SETUP, XFER, WAIT_DONE, CS_HOLD, RSP_WAIT, COMMIT, ARM
  } t_state;

  t_state      r_state;
  logic        r_phase;
  logic [9:0]  r_len;
  logic [7:0]  r_byte0;
  logic [10:0] r_idx;
  logic [15:0] r_gap;
  logic [10:0] r_cmd_addr;
  logic        r_cmd_arm;
  logic        r_spi_cs_n;
  logic        r_spi_start;
  logic [7:0]  r_spi_tx;
  logic [10:0] r_rsp_addr;
  logic [7:0]  r_rsp_data;
  logic        r_rsp_wren;
  logic        r_rsp_commit;
  logic [10:0] r_rsp_commit_len;

  logic w_valid;
  logic w_last;
  logic w_gap_done;

  assign w_valid    = (r_byte0 == 8'(J_CMD_SPI)) && (r_len >= 10'd2) &&
                      ({1'b0, r_len} <= 11'(MAX_LEN));
  assign w_last     = (r_idx == ({1'b0, r_len} - 11'd1));
  assign w_gap_done = (r_gap == 16'(CS_GAP - 1));

  assign cmd_addr       = r_cmd_addr;
  assign cmd_arm        = r_cmd_arm;
  assign spi_cs_n       = r_spi_cs_n;
  assign spi_start      = r_spi_start;
  assign spi_tx         = r_spi_tx;
  assign rsp_addr       = r_rsp_addr;
  assign rsp_data       = r_rsp_data;
  assign rsp_wren       = r_rsp_wren;
  assign rsp_commit     = r_rsp_commit;
  assign rsp_commit_len = r_rsp_commit_len;
  assign busy           = (r_state != IDLE);

  // r_phase splits FETCH and XFER into address and data cycles of the registered-read buffer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state          <= IDLE;
      r_phase          <= 1'b0;
      r_len            <= '0;
      r_byte0          <= '0;
      r_idx            <= '0;
      r_gap            <= '0;
      r_cmd_addr       <= '0;
      r_cmd_arm        <= 1'b0;
      r_spi_cs_n       <= 1'b1;
      r_spi_start      <= 1'b0;
      r_spi_tx         <= '0;
      r_rsp_addr       <= '0;
      r_rsp_data       <= '0;
      r_rsp_wren       <= 1'b0;
      r_rsp_commit     <= 1'b0;
      r_rsp_commit_len <= '0;
    end else begin
      r_spi_start <= 1'b0;
      r_rsp_wren  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (cmd_hasdata) begin
            r_cmd_addr <= '0;
            r_len      <= cmd_len;
            r_phase    <= 1'b0;
            r_state    <= FETCH;
          end
        end
        FETCH: begin
          if (r_phase) begin
            r_byte0 <= cmd_q;
            r_state <= CHECK;
          end else begin
            r_phase <= 1'b1;
          end
        end
        CHECK: begin
          if (w_valid) begin
            r_rsp_addr <= '0;
            r_rsp_data <= r_byte0;
            r_rsp_wren <= 1'b1;
            r_spi_cs_n <= 1'b0;
            r_gap      <= '0;
            r_state    <= CS_SETUP;
          end else begin
            r_cmd_arm <= 1'b1;
            r_state   <= ARM;
          end
        end
        CS_SETUP: begin
          if (w_gap_done) begin
            r_idx      <= 11'd1;
            r_cmd_addr <= 11'd1;
            r_phase    <= 1'b0;
            r_state    <= XFER;
          end else begin
            r_gap <= r_gap + 16'd1;
          end
        end
        XFER: begin
          if (r_phase) begin
            r_spi_tx    <= cmd_q;
            r_spi_start <= 1'b1;
            r_state     <= WAIT_DONE;
          end else begin
            r_phase <= 1'b1;
          end
        end
        WAIT_DONE: begin
          if (spi_done) begin
            r_rsp_addr <= r_idx;
            r_rsp_data <= spi_rx;
            r_rsp_wren <= 1'b1;
            if (w_last) begin
              r_spi_cs_n <= 1'b1;
              r_gap      <= '0;
              r_state    <= CS_HOLD;
            end else begin
              r_idx      <= r_idx + 11'd1;
              r_cmd_addr <= r_idx + 11'd1;
              r_phase    <= 1'b0;
              r_state    <= XFER;
            end
          end
        end
        CS_HOLD: begin
          if (w_gap_done) r_state <= RSP_WAIT;
          else            r_gap   <= r_gap + 16'd1;
        end
        RSP_WAIT: begin
          if (rsp_ready) begin
            r_rsp_commit     <= 1'b1;
            r_rsp_commit_len <= {1'b0, r_len};
            r_state          <= COMMIT;
          end
        end
        COMMIT: begin
          if (rsp_commit_ack) begin
            r_rsp_commit     <= 1'b0;
            r_rsp_commit_len <= '0;
            r_cmd_arm        <= 1'b1;
            r_state          <= ARM;
          end
        end
        ARM: begin
          if (cmd_arm_ack) begin
            r_cmd_arm <= 1'b0;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_flash_cmd_seq.sv
// Scoreboard bench: OUT-buffer memory, flash slave and IN-buffer monitor around the sequencer.
module tb_spi_flash_cmd_seq;
  localparam int CS_GAP = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_hasdata;
  logic [9:0]  cmd_len;
  logic [10:0] cmd_addr;
  logic [7:0]  cmd_q;
  logic        cmd_arm;
  logic        cmd_arm_ack;
  logic        spi_cs_n;
  logic        spi_start;
  logic [7:0]  spi_tx;
  logic [7:0]  spi_rx;
  logic        spi_done;
  logic [10:0] rsp_addr;
  logic [7:0]  rsp_data;
  logic        rsp_wren;
  logic        rsp_ready;
  logic        rsp_commit;
  logic [10:0] rsp_commit_len;
  logic        rsp_commit_ack;
  logic        busy;

  spi_flash_cmd_seq #(.J_CMD_SPI(30), .MAX_LEN(512), .CS_GAP(CS_GAP)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_hasdata(cmd_hasdata), .cmd_len(cmd_len),
    .cmd_addr(cmd_addr), .cmd_q(cmd_q), .cmd_arm(cmd_arm), .cmd_arm_ack(cmd_arm_ack),
    .spi_cs_n(spi_cs_n), .spi_start(spi_start), .spi_tx(spi_tx), .spi_rx(spi_rx),
    .spi_done(spi_done), .rsp_addr(rsp_addr), .rsp_data(rsp_data), .rsp_wren(rsp_wren),
    .rsp_ready(rsp_ready), .rsp_commit(rsp_commit), .rsp_commit_len(rsp_commit_len),
    .rsp_commit_ack(rsp_commit_ack), .busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // OUT buffer with registered read
  logic [7:0] mem [0:2047];
  always @(posedge clk) cmd_q <= mem[cmd_addr];

  logic [18:0] exp_q[$];
  logic [7:0]  tx_q[$];
  logic [7:0]  rx_q[$];
  int          exp_len_q[$];
  int          pkt_starts;
  int          pkt_cs_falls;
  int          commit_cnt;
  int          hi_cnt;
  logic        inject;
  logic [7:0]  pk [8];
  logic [7:0]  rb [8];

  // Flash slave: answers each start with a done pulse two cycles later
  initial begin
    logic [7:0] b;
    logic       prev_cs;
    spi_done = 1'b0;
    spi_rx   = '0;
    prev_cs  = 1'b1;
    forever begin
      @(negedge clk);
      spi_done = 1'b0;
      if (inject && prev_cs && !spi_cs_n) begin
        spi_done = 1'b1;
        spi_rx   = 8'hEE;
        inject   = 1'b0;
      end else if (spi_start) begin
        pkt_starts++;
        check_eq("start_cs_low", 32'(spi_cs_n), 32'd0);
        if (tx_q.size() == 0) check_eq("extra_start", 32'(spi_start), 32'd0);
        else                  check_eq("spi_tx", 32'(spi_tx), 32'(tx_q.pop_front()));
        b = (rx_q.size() != 0) ? rx_q.pop_front() : 8'h00;
        repeat (2) @(negedge clk);
        spi_done = 1'b1;
        spi_rx   = b;
      end
      prev_cs = spi_cs_n;
    end
  end

  // Commit acknowledge one cycle after the request is seen
  initial begin
    rsp_commit_ack = 1'b0;
    forever begin
      @(negedge clk);
      rsp_commit_ack = rsp_commit && !rsp_commit_ack;
    end
  end

  // IN-buffer monitor: writes and commits against the scoreboard
  initial begin
    logic prev_cs, prev_commit;
    logic [18:0] e;
    int el;
    prev_cs = 1'b1; prev_commit = 1'b0; hi_cnt = 0;
    forever begin
      @(negedge clk);
      if (rsp_wren) begin
        if (exp_q.size() == 0) begin
          check_eq("unexp_wren", 32'(rsp_wren), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check_eq("rsp_addr", 32'(rsp_addr), 32'(e[18:8]));
          check_eq("rsp_data", 32'(rsp_data), 32'(e[7:0]));
        end
      end
      if (rsp_commit && !prev_commit) begin
        commit_cnt++;
        if (exp_len_q.size() == 0) begin
          check_eq("unexp_commit", 32'(rsp_commit), 32'd0);
        end else begin
          el = exp_len_q.pop_front();
          $display("commit len=%0d starts=%0d cs_high=%0d", rsp_commit_len, pkt_starts, hi_cnt);
          check_eq("commit_len", 32'(rsp_commit_len), 32'(el));
          check_eq("start_count", 32'(pkt_starts), 32'(el - 1));
          check_eq("cs_windows", 32'(pkt_cs_falls), 32'd1);
          check_eq("cs_gap_before_commit", 32'(hi_cnt >= CS_GAP), 32'd1);
          check_eq("bytes_outstanding", 32'(exp_q.size()), 32'd0);
        end
      end
      if (prev_cs && !spi_cs_n) pkt_cs_falls++;
      hi_cnt      = spi_cs_n ? hi_cnt + 1 : 0;
      prev_cs     = spi_cs_n;
      prev_commit = rsp_commit;
    end
  end

  task automatic start_packet(input int n, output logic valid);
    valid = (pk[0] == 8'd30) && (n >= 2) && (n <= 512);
    for (int k = 0; k < n; k++) mem[k] = pk[k];
    pkt_starts   = 0;
    pkt_cs_falls = 0;
    if (valid) begin
      exp_q.push_back({11'd0, pk[0]});
      for (int k = 1; k < n; k++) begin
        exp_q.push_back({11'(k), rb[k-1]});
        tx_q.push_back(pk[k]);
        rx_q.push_back(rb[k-1]);
      end
      exp_len_q.push_back(n);
    end
    $display("packet len=%0d byte0=%0d valid=%0d", n, pk[0], valid);
    @(negedge clk);
    cmd_len     = 10'(n);
    cmd_hasdata = 1'b1;
  endtask

  task automatic finish_packet(input logic valid);
    int t;
    t = 0;
    while (!cmd_arm && t < 3000) begin
      @(negedge clk); #1;
      t++;
    end
    check_eq("arm_seen", 32'(cmd_arm), 32'd1);
    check_eq("cs_falls", 32'(pkt_cs_falls), valid ? 32'd1 : 32'd0);
    check_eq("wren_left", 32'(exp_q.size()), 32'd0);
    cmd_arm_ack = 1'b1;
    cmd_hasdata = 1'b0;
    @(negedge clk); #1;
    cmd_arm_ack = 1'b0;
    @(negedge clk); #1;
    check_eq("back_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    logic v;
    int t, c0;
    reset_n = 1'b0; cmd_hasdata = 1'b0; cmd_len = '0; cmd_arm_ack = 1'b0;
    rsp_ready = 1'b1; inject = 1'b0; commit_cnt = 0;
    pkt_starts = 0; pkt_cs_falls = 0;
    for (int k = 0; k < 2048; k++) mem[k] = 8'h00;
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_cs_n", 32'(spi_cs_n), 32'd1);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_outs", 32'({spi_start, cmd_arm, rsp_wren, rsp_commit}), 32'd0);
    check_eq("rst_addr", 32'({cmd_addr, rsp_addr, rsp_commit_len}), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // read-ID style: 0x9F plus three dummy bytes
    pk = '{8'd30, 8'h9F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    rb = '{8'hFF, 8'h20, 8'hBA, 8'h19, 8'h00, 8'h00, 8'h00, 8'h00};
    start_packet(5, v); finish_packet(v);

    // read status register
    pk = '{8'd30, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    rb = '{8'h5A, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    start_packet(3, v); finish_packet(v);

    // wrong command code, then too short
    pk = '{8'd7, 8'd1, 8'd2, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    start_packet(3, v); finish_packet(v);
    pk = '{8'd30, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    start_packet(1, v); finish_packet(v);

    // stray spi_done while CS is settling
    pk = '{8'd30, 8'hAB, 8'h11, 8'h22, 8'h00, 8'h00, 8'h00, 8'h00};
    rb = '{8'h01, 8'h02, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    inject = 1'b1;
    start_packet(4, v); finish_packet(v);
    check_eq("inject_consumed", 32'(inject), 32'd0);

    // IN buffer not ready for 100 cycles after the transfer
    rsp_ready = 1'b0;
    pk = '{8'd30, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    rb = '{8'h77, 8'h81, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    start_packet(3, v);
    t = 0;
    while (!(pkt_cs_falls == 1 && spi_cs_n) && t < 2000) begin
      @(negedge clk); #1;
      t++;
    end
    check_eq("xfer_ended", 32'(spi_cs_n), 32'd1);
    c0 = commit_cnt;
    repeat (100) @(negedge clk);
    #1;
    check_eq("stall_busy", 32'(busy), 32'd1);
    check_eq("stall_no_commit", 32'(commit_cnt), 32'(c0));
    rsp_ready = 1'b1;
    t = 0;
    while (commit_cnt == c0 && t < 2) begin
      @(negedge clk); #1;
      t++;
    end
    check_eq("commit_latency", 32'(commit_cnt), 32'(c0 + 1));
    finish_packet(v);

    // reset during the second byte of a 5-byte packet
    pk = '{8'd30, 8'h03, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00};
    rb = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'h00, 8'h00, 8'h00, 8'h00};
    start_packet(5, v);
    t = 0;
    while (pkt_starts < 2 && t < 2000) begin
      @(negedge clk); #1;
      t++;
    end
    check_eq("second_start", 32'(pkt_starts), 32'd2);
    c0 = commit_cnt;
    @(negedge clk); #2;
    reset_n = 1'b0;
    cmd_hasdata = 1'b0;
    #1;
    check_eq("mid_rst_cs_n", 32'(spi_cs_n), 32'd1);
    check_eq("mid_rst_outs", 32'({spi_start, cmd_arm, rsp_wren, rsp_commit, busy}), 32'd0);
    check_eq("mid_rst_addr", 32'({cmd_addr, rsp_addr, rsp_commit_len}), 32'd0);
    check_eq("mid_rst_data", 32'({spi_tx, rsp_data}), 32'd0);
    exp_q.delete(); tx_q.delete(); rx_q.delete(); exp_len_q.delete();
    repeat (5) @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    check_eq("post_rst_idle", 32'(busy), 32'd0);
    check_eq("post_rst_no_arm", 32'(cmd_arm), 32'd0);
    check_eq("post_rst_no_commit", 32'(commit_cnt), 32'(c0));

    // normal operation after reset, random payload
    pk[0] = 8'd30;
    for (int k = 1; k < 8; k++) pk[k] = 8'($urandom_range(0, 255));
    for (int k = 0; k < 8; k++) rb[k] = 8'($urandom_range(0, 255));
    start_packet(6, v); finish_packet(v);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
